// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity, stop period.
// Bit timing is driven by a 16x baud strobe; tx is taken straight from a flop.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bd_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_done;

  logic w_bit_end;
  assign w_bit_end = bd_tick && (r_tick == TW'(15));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start bit begins on the accept edge, not on a baud tick.
          if (tx_start) begin
            r_shift  <= tx_data;
            r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
            r_tick   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else if (bd_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + BW'(1);
            if (r_bit == BW'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx <= r_shift[1];
            end
          end else if (bd_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else if (bd_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_STOP: begin
          if (bd_tick && (r_tick == TW'(STOP_TICKS - 1))) begin
            r_tick  <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (bd_tick) begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) sharing clock, reset and baud strobe.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bd_tick = 1'b1;
  logic [3:0] start = 4'b0000;
  logic [7:0] dat [4];
  logic [3:0] tx_w, rdy_w, done_w;

  int checks = 0;
  int errors = 0;
  int period = 1;
  int div = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_TICKS(16)) u_8n1 (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .tx_start(start[0]), .tx_data(dat[0]),
    .tx_ready(rdy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_TICKS(16)) u_8e1 (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .tx_start(start[1]), .tx_data(dat[1]),
    .tx_ready(rdy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_TICKS(16)) u_8o1 (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .tx_start(start[2]), .tx_data(dat[2]),
    .tx_ready(rdy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_TICKS(32)) u_8n2 (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .tx_start(start[3]), .tx_data(dat[3]),
    .tx_ready(rdy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; ticked reports whether the edge just passed carried bd_tick.
  task automatic step(output logic ticked);
    ticked = bd_tick;
    @(negedge clk);
    if (done_w[0] === 1'b1) done_cnt0++;
    div = (div + 1) % period;
    bd_tick = (div == 0);
  endtask

  task automatic idle(input int n);
    logic tk;
    for (int i = 0; i < n; i++) begin
      step(tk);
      chk("idle_tx", tx_w[0], 1'b1);
    end
  endtask

  // Sends one frame on instance idx and checks every clock against a tick-count line model.
  task automatic send(input int idx, input logic [7:0] d, input logic [7:0] d_after,
                      input int pen, input int podd, input int stop_t,
                      input bit hold, input bit pulse, input int rst_at,
                      output logic [7:0] rx, output logic rx_par);
    int   t, len, s;
    logic tk, par, e;
    len    = (9 + pen) * 16 + stop_t;
    par    = (^d) ^ podd[0];
    rx     = '0;
    rx_par = 1'b0;
    start[idx] = 1'b1;
    dat[idx]   = d;
    step(tk);
    chk("accept_tx", tx_w[idx], 1'b0);
    chk("accept_ready", rdy_w[idx], 1'b0);
    chk("accept_done", done_w[idx], 1'b0);
    start[idx] = hold;
    dat[idx]   = d_after;
    t = 0;
    while (t < len) begin
      if (pulse) begin
        start[idx] = (t == 40) || (t == 100);
        if (t == 50) dat[idx] = ~d_after;
      end
      step(tk);
      if (tk) t++;
      if (rst_at > 0 && t == rst_at) begin
        rst = 1'b1;
        step(tk);
        rst = 1'b0;
        chk("rst_tx", tx_w[idx], 1'b1);
        chk("rst_ready", rdy_w[idx], 1'b1);
        chk("rst_done", done_w[idx], 1'b0);
        return;
      end
      s = t / 16;
      if (s == 0)                e = 1'b0;
      else if (s <= 8)           e = d[s-1];
      else if (pen != 0 && s == 9) e = par;
      else                       e = 1'b1;
      chk("tx_line", tx_w[idx], e);
      chk("tx_ready", rdy_w[idx], t == len);
      chk("tx_done", done_w[idx], tk && (t == len));
      if (tk && (t % 16) == 8) begin
        if (s >= 1 && s <= 8) rx[s-1] = tx_w[idx];
        if (pen != 0 && s == 9) rx_par = tx_w[idx];
      end
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic       rp;
    logic       tk;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;

    rst = 1'b1;
    step(tk);
    step(tk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("reset_tx", tx_w[i], 1'b1);
      chk("reset_ready", rdy_w[i], 1'b1);
      chk("reset_done", done_w[i], 1'b0);
    end
    idle(3);

    // 8N1, tick every clock
    done_cnt0 = 0;
    send(0, 8'h55, 8'h55, 0, 0, 16, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_55", rx, 8'h55);
    idle(5);
    chk("done_cnt_55", done_cnt0, 1);

    // Even / odd parity on 0xA3 (four ones)
    send(1, 8'hA3, 8'hA3, 1, 0, 16, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_a3_even", rx, 8'hA3);
    chk("parity_even_slot", rp, 1'b0);
    send(2, 8'hA3, 8'hA3, 1, 1, 16, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_a3_odd", rx, 8'hA3);
    chk("parity_odd_slot", rp, 1'b1);

    // Tick every fourth clock
    period = 4;
    div = 0;
    bd_tick = 1'b0;
    send(0, 8'h0F, 8'h0F, 0, 0, 16, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_0f_slow", rx, 8'h0F);
    period = 1;
    div = 0;
    bd_tick = 1'b1;
    idle(5);

    // Back-to-back with start held, then mid-frame pulses and data changes
    done_cnt0 = 0;
    send(0, 8'h12, 8'h34, 0, 0, 16, 1'b1, 1'b0, 0, rx, rp);
    chk("rx_12", rx, 8'h12);
    send(0, 8'h34, 8'h34, 0, 0, 16, 1'b0, 1'b1, 0, rx, rp);
    chk("rx_34", rx, 8'h34);
    idle(200);
    chk("done_cnt_b2b", done_cnt0, 2);

    // Two stop bits
    send(3, 8'h3C, 8'h3C, 0, 0, 32, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_3c_stop32", rx, 8'h3C);
    idle(5);

    // Reset during data bit 3, then a clean frame
    done_cnt0 = 0;
    send(0, 8'hFF, 8'hFF, 0, 0, 16, 1'b0, 1'b0, 70, rx, rp);
    idle(40);
    chk("done_cnt_after_rst", done_cnt0, 0);
    send(0, 8'h81, 8'h81, 0, 0, 16, 1'b0, 1'b0, 0, rx, rp);
    chk("rx_81", rx, 8'h81);
    idle(5);
    chk("done_cnt_81", done_cnt0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
